// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (16 ticks per bit, LSB first, idle-high line).
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous active-low reset
//   tick_i         oversample strobe, one clk wide, 16 per bit period
//   rx_i           serial line (synchronised internally before use)
//   dout_o         last received data word, held until the next completed frame
//   rx_done_tick_o one-clk pulse in the cycle after the stop-bit sample
//   frame_err_o    stop bit of the last frame was sampled low
//   state_o        current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//   parity_err_o   parity mismatch on the last frame (UART_RX_PARITY_EN only)
//
// Build option: define UART_RX_PARITY_EN to add a parity bit between the data
// bits and the stop bit, the parity_err_o output and the ODD parameter
// (0 = even parity, 1 = odd parity).
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          ODD     = 1'b0
`endif
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            tick_i,
  input  logic            rx_i,
  output logic [DBIT-1:0] dout_o,
  output logic            rx_done_tick_o,
  output logic            frame_err_o,
  output logic [2:0]      state_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err_o
`endif
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [3:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            sync1;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
`endif

  assign state_o = state;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state          <= IDLE;
      s              <= '0;
      n              <= '0;
      b              <= '0;
      dout_o         <= '0;
      rx_done_tick_o <= 1'b0;
      frame_err_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad        <= 1'b0;
      parity_err_o   <= 1'b0;
`endif
    end else begin
      rx_done_tick_o <= 1'b0;
      case (state)
        // Start detection does not wait for a tick.
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        // Re-check the line at the middle of the start bit to reject glitches.
        START: begin
          if (tick_i) begin
            if (s == 4'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_i) begin
            if (s == 4'd15) begin
              b <= {rx_s, b[DBIT-1:1]};
              s <= '0;
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        // Mismatch flag is held until STOP so it publishes alongside dout_o.
        PARITY: begin
          if (tick_i) begin
            if (s == 4'd15) begin
              par_bad <= rx_s ^ (^b) ^ ODD;
              s       <= '0;
              state   <= STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick_i) begin
            if (s == SB_LAST) begin
              state          <= IDLE;
              dout_o         <= b;
              frame_err_o    <= ~rx_s;
              rx_done_tick_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_o   <= par_bad;
`endif
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Frames are driven bit by bit, each bit held for 16 oversample ticks.
// The tick strobe comes from a local divider: tick_div=1 ties it high,
// larger values give a one-clk strobe every tick_div clocks (the 100 MHz /
// 651 rate is scaled down to keep run time short).
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int unsigned PX = 16;
`else
  localparam int unsigned PX = 0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       tick_i;
  logic       rx_i = 1'b1;
  logic [7:0] dout_o;
  logic       rx_done_tick_o;
  logic       frame_err_o;
  logic [2:0] state_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .tick_i         (tick_i),
    .rx_i           (rx_i),
    .dout_o         (dout_o),
    .rx_done_tick_o (rx_done_tick_o),
    .frame_err_o    (frame_err_o),
    .state_o        (state_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o   (parity_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned tick_div = 1;
  int unsigned tcnt = 0;
  always @(posedge clk_i) tcnt <= (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
  assign tick_i = (tcnt == 0);

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Done-pulse monitor: count pulses, pulses wider than one clk, capture data.
  int unsigned done_cnt = 0;
  int unsigned wide_cnt = 0;
  int unsigned done_cyc = 0;
  logic        prev_done = 1'b0;
  logic [7:0]  done_dout[$];
  always @(negedge clk_i) begin
    if (rx_done_tick_o) begin
      done_cnt++;
      done_cyc = cyc;
      done_dout.push_back(dout_o);
      if (prev_done) wide_cnt++;
    end
    prev_done = rx_done_tick_o;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int unsigned start_cyc = 0;

  task automatic hold_bit(input logic v);
    rx_i = v;
    repeat (16 * tick_div) @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int unsigned cycles);
    rx_i = 1'b1;
    repeat (cycles) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    start_cyc = cyc;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(par);
`endif
    hold_bit(stop);
    rx_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned base;
  int unsigned qbase;

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_dout", dout_o, 8'h00);
    check("rst_done", rx_done_tick_o, 1'b0);
    check("rst_ferr", frame_err_o, 1'b0);
    check("rst_state", state_o, 3'd0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", parity_err_o, 1'b0);
`endif
    reset_i = 1'b1;
    idle(5);

    // Clean frame 0xA5 with tick tied high
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    check("a5_pulses", done_cnt - base, 1);
    check("a5_width", wide_cnt, 0);
    check("a5_dout", dout_o, 8'hA5);
    check("a5_ferr", frame_err_o, 1'b0);
    check("a5_latency", done_cyc - start_cyc, 155 + PX);
    check("a5_state", state_o, 3'd0);
`ifdef UART_RX_PARITY_EN
    check("a5_perr", parity_err_o, 1'b0);
`endif

    // Start glitch: low for 4 ticks then high
    base = done_cnt;
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("glitch_in_start", state_o, 3'd1);
    idle(30);
    check("glitch_state", state_o, 3'd0);
    check("glitch_pulses", done_cnt - base, 0);
    check("glitch_dout", dout_o, 8'hA5);

    // Framing error on 0x3C, then clean 0x00 clears it
    base = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    check("3c_pulses", done_cnt - base, 1);
    check("3c_dout", dout_o, 8'h3C);
    check("3c_ferr", frame_err_o, 1'b1);
    base = done_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    idle(4);
    check("00_pulses", done_cnt - base, 1);
    check("00_dout", dout_o, 8'h00);
    check("00_ferr", frame_err_o, 1'b0);

    // Reset after 3 data bits of 0xFF
    base = done_cnt;
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b1);
    hold_bit(1'b1);
    check("ff_in_data", state_o, 3'd2);
    reset_i = 1'b0;
    rx_i = 1'b1;
    #1;
    check("mrst_dout", dout_o, 8'h00);
    check("mrst_done", rx_done_tick_o, 1'b0);
    check("mrst_ferr", frame_err_o, 1'b0);
    check("mrst_state", state_o, 3'd0);
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    idle(40);
    check("mrst_pulses", done_cnt - base, 0);
    base = done_cnt;
    send_frame(8'h81, 1'b0, 1'b1);
    idle(4);
    check("81_pulses", done_cnt - base, 1);
    check("81_dout", dout_o, 8'h81);
    check("81_ferr", frame_err_o, 1'b0);

    // Back-to-back 0x55, 0xAA with a divided tick
    tick_div = 4;
    idle(8);
    qbase = done_dout.size();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    idle(64);
    check("b2b_count", done_dout.size() - qbase, 2);
    if (done_dout.size() >= qbase + 2) begin
      check("b2b_first", done_dout[qbase], 8'h55);
      check("b2b_second", done_dout[qbase + 1], 8'hAA);
    end
    check("b2b_dout", dout_o, 8'hAA);
    check("b2b_width", wide_cnt, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity on 0x07 (three ones -> parity bit 1)
    tick_div = 1;
    idle(8);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("par_ok_dout", dout_o, 8'h07);
    check("par_ok_perr", parity_err_o, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
    check("par_bad_dout", dout_o, 8'h07);
    check("par_bad_perr", parity_err_o, 1'b1);
    check("par_bad_ferr", frame_err_o, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, number of oversample ticks in the stop bit (16 = 1 stop bit).
REQ-003 clk_i  input  1  system clock, 100 MHz.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 tick_i  input  1  oversample strobe from baud_generator; 16 ticks per bit period; one clk wide.
REQ-006 rx_i  input  1  serial line, idle high, LSB first.
REQ-007 dout_o  output  DBIT  last received data word.
REQ-008 rx_done_tick_o  output  1  one-clk pulse when a frame completes.
REQ-009 frame_err_o  output  1  stop bit of the last frame sampled low.
REQ-010 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-011 rx_i SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s).
REQ-012 FSM states SHALL be IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
REQ-013 Internal counters: s (4 bits, tick count), n (ceil(log2 DBIT) bits, bit index), b (DBIT-bit shift register).
REQ-014 IDLE: rx_s==0 -> START with s=0; tick_i is ignored while in IDLE.
REQ-015 START: on tick_i with s==7, if rx_s==0 -> DATA with s=0, n=0; if rx_s==1 (glitch) -> IDLE with no outputs changed; else on tick_i s increments.
REQ-016 DATA: on tick_i with s==15, b = {rx_s, b[DBIT-1:1]}, s=0; if n==DBIT-1 -> PARITY (macro defined) or STOP, else n increments; else on tick_i s increments.
REQ-017 STOP: on tick_i with s==SB_TICK-1 -> IDLE, dout_o<=b, frame_err_o<=~rx_s, rx_done_tick_o=1 for the following clk cycle only.
REQ-018 Cycles without tick_i SHALL hold s, n, b and state, except for the IDLE->START transition.
REQ-019 Latency: rx_done_tick_o is asserted in the clk cycle immediately after the edge that captured the stop-bit sample.
REQ-020 dout_o and frame_err_o SHALL hold their values until the next completed frame.
REQ-021 A start edge arriving in the cycle of the STOP->IDLE transition SHALL be detected in the next cycle; back-to-back frames SHALL not be dropped.

Reset
REQ-022 reset_i==0 SHALL asynchronously force state=IDLE, s=0, n=0, b=0, dout_o=0, rx_done_tick_o=0, frame_err_o=0, and synchronizer flops=1 (idle line).
REQ-023 Reset asserted mid-frame SHALL discard the partial frame and produce no rx_done_tick_o pulse.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state is compiled in, along with output parity_err_o (1 bit, reset 0) and parameter ODD (default 0 = even).
REQ-025 With UART_RX_PARITY_EN, the PARITY state samples at s==15 and compares rx_s against the parity of b (even: ^b; odd: ~^b), then goes to STOP; parity_err_o updates together with dout_o.
REQ-026 Without UART_RX_PARITY_EN, the PARITY state, parity_err_o and ODD SHALL not exist; DATA goes directly to STOP.

Verification
REQ-027 tick_i tied high, frame 0xA5 with a valid stop bit -> dout_o=0xA5, rx_done_tick_o high for exactly 1 clk, frame_err_o=0.
REQ-028 rx_i low for 4 ticks, then high -> state returns to IDLE, no rx_done_tick_o, dout_o unchanged.
REQ-029 Frame 0x3C with stop bit driven 0 -> dout_o=0x3C, frame_err_o=1; then a clean frame 0x00 -> frame_err_o=0.
REQ-030 reset_i pulsed low after 3 data bits of frame 0xFF -> all outputs 0 and state=IDLE; the next frame 0x81 is received correctly.
REQ-031 Back-to-back frames 0x55 then 0xAA with no idle gap, using baud_generator M=651 ticks -> two done pulses with matching dout_o values.
REQ-032 UART_RX_PARITY_EN, ODD=0: frame 0x07 with parity bit 1 -> parity_err_o=0; the same frame with parity bit 0 -> parity_err_o=1.
